// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between requester A (CPU)
// and requester B (loader/debug), with I/O-mapped addresses filtered out as errors.
module data_memory_arbiter #(
    parameter int                    ADDR_WIDTH    = 10,
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] IN_PORT_ADDR  = 10'h3FE,
    parameter logic [ADDR_WIDTH-1:0] OUT_PORT_ADDR = 10'h3FF,
    parameter bit                    PRIO_A_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_a_req,
    input  logic                  in_a_write,
    input  logic [ADDR_WIDTH-1:0] in_a_addr,
    input  logic [DATA_WIDTH-1:0] in_a_data,
    output logic                  out_a_ack,
    output logic                  out_a_err,
    output logic [DATA_WIDTH-1:0] out_a_data,
    input  logic                  in_b_req,
    input  logic                  in_b_write,
    input  logic [ADDR_WIDTH-1:0] in_b_addr,
    input  logic [DATA_WIDTH-1:0] in_b_data,
    output logic                  out_b_ack,
    output logic                  out_b_err,
    output logic [DATA_WIDTH-1:0] out_b_data,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic                  out_mem_write_en,
    output logic                  out_mem_read_en,
    output logic [DATA_WIDTH-1:0] out_mem_data,
    input  logic [DATA_WIDTH-1:0] in_mem_data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    function automatic logic is_reserved(input logic [ADDR_WIDTH-1:0] addr);
        return (addr == IN_PORT_ADDR) || (addr == OUT_PORT_ADDR);
    endfunction

    logic [1:0]            state_r;
    logic                  owner_b_r;   // 0: A owns the current access, 1: B
    logic                  last_b_r;    // side served most recently
    logic                  cmd_write_r;
    logic                  cmd_err_r;

    logic                  grant_b_s;
    logic                  sel_write_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic                  sel_err_s;

    // Grant selection: a tie goes to the side not served last
    always_comb begin
        grant_b_s   = 1'b0;
        sel_write_s = in_a_write;
        sel_addr_s  = in_a_addr;
        sel_data_s  = in_a_data;
        if (in_b_req && (!in_a_req || !last_b_r)) begin
            grant_b_s   = 1'b1;
            sel_write_s = in_b_write;
            sel_addr_s  = in_b_addr;
            sel_data_s  = in_b_data;
        end else begin
            grant_b_s   = 1'b0;
        end
        sel_err_s = is_reserved(sel_addr_s);
    end

    // Three-state access sequencer driving memory pins and requester responses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            owner_b_r        <= 1'b0;
            last_b_r         <= PRIO_A_FIRST;
            cmd_write_r      <= 1'b0;
            cmd_err_r        <= 1'b0;
            out_a_ack        <= 1'b0;
            out_a_err        <= 1'b0;
            out_a_data       <= {DATA_WIDTH{1'b0}};
            out_b_ack        <= 1'b0;
            out_b_err        <= 1'b0;
            out_b_data       <= {DATA_WIDTH{1'b0}};
            out_mem_addr     <= {ADDR_WIDTH{1'b0}};
            out_mem_write_en <= 1'b0;
            out_mem_read_en  <= 1'b0;
            out_mem_data     <= {DATA_WIDTH{1'b0}};
        end else begin
            out_a_ack <= 1'b0;
            out_a_err <= 1'b0;
            out_b_ack <= 1'b0;
            out_b_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_a_req || in_b_req) begin
                        owner_b_r   <= grant_b_s;
                        cmd_write_r <= sel_write_s;
                        cmd_err_r   <= sel_err_s;
                        // Reserved addresses never appear on the memory bus
                        if (!sel_err_s) begin
                            out_mem_addr <= sel_addr_s;
                            out_mem_data <= sel_data_s;
                        end else begin
                            out_mem_addr <= out_mem_addr;
                            out_mem_data <= out_mem_data;
                        end
                        out_mem_write_en <= sel_write_s && !sel_err_s;
                        out_mem_read_en  <= !sel_write_s && !sel_err_s;
                        state_r          <= ST_ACCESS;
                    end else begin
                        out_mem_write_en <= 1'b0;
                        out_mem_read_en  <= 1'b0;
                        state_r          <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    out_mem_write_en <= 1'b0;
                    out_mem_read_en  <= 1'b0;
                    last_b_r         <= owner_b_r;
                    if (!cmd_write_r) begin
                        if (owner_b_r) begin
                            out_b_data <= cmd_err_r ? {DATA_WIDTH{1'b0}} : in_mem_data;
                        end else begin
                            out_a_data <= cmd_err_r ? {DATA_WIDTH{1'b0}} : in_mem_data;
                        end
                    end else begin
                        out_a_data <= out_a_data;
                        out_b_data <= out_b_data;
                    end
                    if (owner_b_r) begin
                        out_b_ack <= 1'b1;
                        out_b_err <= cmd_err_r;
                    end else begin
                        out_a_ack <= 1'b1;
                        out_a_err <= cmd_err_r;
                    end
                    state_r <= ST_ACK;
                end
                ST_ACK: begin
                    out_mem_write_en <= 1'b0;
                    out_mem_read_en  <= 1'b0;
                    state_r          <= ST_IDLE;
                end
                default: begin
                    out_mem_write_en <= 1'b0;
                    out_mem_read_en  <= 1'b0;
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: queued drivers per requester, a memory
// model on the bus, and a transaction-level reference model evaluated in ack order.
module tb_data_memory_arbiter;

    typedef struct packed {
        logic       wr;
        logic [9:0] addr;
        logic [7:0] data;
        logic [2:0] gap;
    } cmd_t;

    typedef struct {
        int side;
        int cyc;
    } hist_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_d [2];
    logic       wr_d [2];
    logic [9:0] addr_d [2];
    logic [7:0] data_d [2];
    logic       ack_s [2];
    logic       err_s [2];
    logic [7:0] dat_s [2];

    logic       out_a_ack, out_a_err, out_b_ack, out_b_err;
    logic [7:0] out_a_data, out_b_data;
    logic [9:0] out_mem_addr;
    logic       out_mem_write_en, out_mem_read_en;
    logic [7:0] out_mem_data, in_mem_data;

    logic [7:0] tb_mem [1024];
    logic [7:0] ref_mem [1024];
    logic [7:0] init_mem [1024];

    cmd_t  pend_a[$], pend_b[$], exp_a[$], exp_b[$];
    int    lc_a[$], lc_b[$];
    hist_t hist[$];
    bit    busy [2];
    int    gapc [2];
    int    last_lat [2];
    int    acks [2];
    logic [7:0] prev_d [2];
    int    cyc = 0;
    int    inv_err = 0;
    int    total = 0;
    int    passed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign ack_s[0] = out_a_ack;
    assign ack_s[1] = out_b_ack;
    assign err_s[0] = out_a_err;
    assign err_s[1] = out_b_err;
    assign dat_s[0] = out_a_data;
    assign dat_s[1] = out_b_data;

    data_memory_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .in_a_req(req_d[0]), .in_a_write(wr_d[0]), .in_a_addr(addr_d[0]), .in_a_data(data_d[0]),
        .out_a_ack(out_a_ack), .out_a_err(out_a_err), .out_a_data(out_a_data),
        .in_b_req(req_d[1]), .in_b_write(wr_d[1]), .in_b_addr(addr_d[1]), .in_b_data(data_d[1]),
        .out_b_ack(out_b_ack), .out_b_err(out_b_err), .out_b_data(out_b_data),
        .out_mem_addr(out_mem_addr), .out_mem_write_en(out_mem_write_en),
        .out_mem_read_en(out_mem_read_en), .out_mem_data(out_mem_data),
        .in_mem_data(in_mem_data)
    );

    // Memory model on the bus: write at the edge, asynchronous read while enabled
    assign in_mem_data = out_mem_read_en ? tb_mem[out_mem_addr] : 8'hEE;
    always @(posedge clk) if (out_mem_write_en) tb_mem[out_mem_addr] = out_mem_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_res(input logic [9:0] a);
        return (a == 10'd1022) || (a == 10'd1023);
    endfunction

    function automatic int pend_size(input int s);
        return (s == 0) ? pend_a.size() : pend_b.size();
    endfunction

    function automatic int exp_size(input int s);
        return (s == 0) ? exp_a.size() : exp_b.size();
    endfunction

    task automatic push_cmd(input int s, input logic wr, input logic [9:0] a,
                            input logic [7:0] d, input logic [2:0] g);
        cmd_t c;
        c = '{wr: wr, addr: a, data: d, gap: g};
        if (s == 0) pend_a.push_back(c);
        else pend_b.push_back(c);
    endtask

    // Requester driver: presents queued commands, holds req until ack
    task automatic drive(input int s);
        cmd_t c;
        int   wait_n;
        c = '0;
        wait_n = 0;
        forever begin
            @(negedge clk);
            if (busy[s]) begin
                if (ack_s[s]) begin
                    busy[s] = 1'b0;
                    req_d[s] = 1'b0;
                    gapc[s] = int'(c.gap);
                end else begin
                    wait_n++;
                    if (wait_n > 60) begin
                        chk((s == 0) ? "a_ack_timeout" : "b_ack_timeout", 32'd0, 32'd1);
                        busy[s] = 1'b0;
                        req_d[s] = 1'b0;
                    end
                end
            end
            if (!busy[s]) begin
                if (gapc[s] > 0) gapc[s]--;
                else if (pend_size(s) > 0) begin
                    c = (s == 0) ? pend_a.pop_front() : pend_b.pop_front();
                    req_d[s] = 1'b1;
                    wr_d[s] = c.wr;
                    addr_d[s] = c.addr;
                    data_d[s] = c.data;
                    if (s == 0) begin exp_a.push_back(c); lc_a.push_back(cyc); end
                    else begin exp_b.push_back(c); lc_b.push_back(cyc); end
                    busy[s] = 1'b1;
                    wait_n = 0;
                end
            end
        end
    endtask

    // Reference model: each ack is one completed transaction, applied in ack order
    task automatic handle_ack(input int s);
        cmd_t c;
        int lc;
        logic [7:0] ed;
        bit res;
        if (exp_size(s) == 0) begin
            chk((s == 0) ? "a_unexpected_ack" : "b_unexpected_ack", 32'd1, 32'd0);
        end else begin
            if (s == 0) begin c = exp_a.pop_front(); lc = lc_a.pop_front(); end
            else begin c = exp_b.pop_front(); lc = lc_b.pop_front(); end
            res = is_res(c.addr);
            if (c.wr) ed = prev_d[s];
            else ed = res ? 8'h00 : ref_mem[c.addr];
            if (c.wr && !res) ref_mem[c.addr] = c.data;
            prev_d[s] = ed;
            chk((s == 0) ? "a_err" : "b_err", {31'd0, err_s[s]}, {31'd0, res});
            chk((s == 0) ? "a_data" : "b_data", {24'd0, dat_s[s]}, {24'd0, ed});
            last_lat[s] = cyc - lc;
            hist.push_back('{side: s, cyc: cyc});
            acks[s]++;
        end
    endtask

    // Monitor: pops the scoreboard on every ack and tracks bus invariants
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_d[0] = 8'h00;
            prev_d[1] = 8'h00;
        end else begin
            if (out_mem_write_en && out_mem_read_en) inv_err++;
            if ((out_mem_write_en || out_mem_read_en) && is_res(out_mem_addr)) inv_err++;
            if (out_a_ack && out_b_ack) inv_err++;
            for (int s = 0; s < 2; s++) begin
                if (ack_s[s]) handle_ack(s);
                else begin
                    if (err_s[s]) inv_err++;
                    if (dat_s[s] !== prev_d[s]) inv_err++;
                end
            end
        end
    end

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((pend_a.size() + pend_b.size() + exp_a.size() + exp_b.size() != 0 ||
                busy[0] || busy[1] || gapc[0] != 0 || gapc[1] != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk("wait_idle_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic wait_bus(input bit want_write, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (want_write ? out_mem_write_en : out_mem_read_en) seen = 1'b1;
        end
    endtask

    initial begin
        int  hb;
        int  a_before;
        int  bad;
        bit  seen;
        logic [9:0] ra;
        int  r;

        for (int i = 0; i < 1024; i++) begin
            tb_mem[i] = i[7:0] ^ 8'h5C;
            ref_mem[i] = tb_mem[i];
            init_mem[i] = tb_mem[i];
        end
        for (int s = 0; s < 2; s++) begin
            req_d[s] = 1'b0; wr_d[s] = 1'b0; addr_d[s] = 10'd0; data_d[s] = 8'd0;
            busy[s] = 1'b0; gapc[s] = 0; last_lat[s] = 0; acks[s] = 0; prev_d[s] = 8'h00;
        end
        rst_n = 1'b0;
        fork
            drive(0);
            drive(1);
        join_none

        // Reset: all outputs low
        repeat (2) @(negedge clk);
        chk("rst_a_ack", {31'd0, out_a_ack}, 32'd0);
        chk("rst_b_ack", {31'd0, out_b_ack}, 32'd0);
        chk("rst_a_err", {31'd0, out_a_err}, 32'd0);
        chk("rst_b_err", {31'd0, out_b_err}, 32'd0);
        chk("rst_a_data", {24'd0, out_a_data}, 32'd0);
        chk("rst_b_data", {24'd0, out_b_data}, 32'd0);
        chk("rst_mem_en", {30'd0, out_mem_write_en, out_mem_read_en}, 32'd0);
        chk("rst_mem_addr", {22'd0, out_mem_addr}, 32'd0);
        chk("rst_mem_data", {24'd0, out_mem_data}, 32'd0);

        // First tie after reset goes to A
        #1;
        hb = hist.size();
        push_cmd(0, 1'b1, 10'h040, 8'h11, 3'd0);
        push_cmd(1, 1'b0, 10'h041, 8'h00, 3'd0);
        rst_n = 1'b1;
        wait_idle(100);
        chk("first_tie_side", hist[hb].side, 32'd0);

        // A write 0x05 <- 0x5A, then read it back
        push_cmd(0, 1'b1, 10'h005, 8'h5A, 3'd0);
        wait_bus(1'b1, seen);
        chk("a_wr_we_seen", {31'd0, seen}, 32'd1);
        chk("a_wr_mem_addr", {22'd0, out_mem_addr}, 32'h005);
        chk("a_wr_mem_data", {24'd0, out_mem_data}, 32'h5A);
        chk("a_wr_no_re", {31'd0, out_mem_read_en}, 32'd0);
        wait_idle(100);
        chk("a_wr_latency", last_lat[0], 32'd2);
        push_cmd(0, 1'b0, 10'h005, 8'h00, 3'd0);
        wait_idle(100);
        chk("a_rd_held_data", {24'd0, out_a_data}, 32'h5A);

        // Continuous contention: strict alternation, each side every 6 cycles
        hb = hist.size();
        for (int i = 0; i < 4; i++) begin
            push_cmd(0, 1'b1, 10'h010 + 10'(i), 8'hC0 + 8'(i), 3'd0);
            push_cmd(1, 1'b0, 10'h020 + 10'(i), 8'h00, 3'd0);
        end
        wait_idle(200);
        chk("contend_count", hist.size() - hb, 32'd8);
        for (int i = hb + 1; i < hist.size(); i++)
            chk("contend_alternate", {31'd0, hist[i].side != hist[i-1].side}, 32'd1);
        for (int i = hb + 2; i < hist.size(); i++)
            chk("contend_interval", hist[i].cyc - hist[i-2].cyc, 32'd6);

        // Reserved addresses from B
        push_cmd(1, 1'b0, 10'h3FE, 8'h00, 3'd0);
        push_cmd(1, 1'b1, 10'h3FF, 8'h77, 3'd0);
        wait_idle(100);
        chk("b_res_data", {24'd0, out_b_data}, 32'h00);
        chk("res_mem_untouched", {24'd0, tb_mem[10'h3FF]}, {24'd0, init_mem[10'h3FF]});

        // Reset at the closing edge of an A read's access cycle
        a_before = acks[0];
        push_cmd(0, 1'b0, 10'h005, 8'h00, 3'd0);
        wait_bus(1'b0, seen);
        chk("mid_rst_re_seen", {31'd0, seen}, 32'd1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_no_ack", {31'd0, out_a_ack}, 32'd0);
        chk("mid_rst_en_low", {30'd0, out_mem_write_en, out_mem_read_en}, 32'd0);
        #1 rst_n = 1'b1;
        wait_idle(100);
        chk("mid_rst_one_ack", acks[0] - a_before, 32'd1);
        chk("mid_rst_reissue_data", {24'd0, out_a_data}, 32'h5A);

        // B holds req through its ack: back-to-back second access
        push_cmd(1, 1'b0, 10'h010, 8'h00, 3'd0);
        push_cmd(1, 1'b0, 10'h011, 8'h00, 3'd0);
        wait_idle(100);
        chk("b_b2b_latency", last_lat[1], 32'd3);
        chk("b_b2b_data", {24'd0, out_b_data}, 32'hC1);

        // A req pulsed while B owns the memory: not queued
        a_before = acks[0];
        push_cmd(1, 1'b0, 10'h020, 8'h00, 3'd0);
        wait_bus(1'b0, seen);
        #1;
        req_d[0] = 1'b1; wr_d[0] = 1'b0; addr_d[0] = 10'h030;
        @(negedge clk);
        #1 req_d[0] = 1'b0;
        wait_idle(100);
        repeat (6) @(negedge clk);
        chk("pulse_not_served", acks[0] - a_before, 32'd0);

        // Randomised traffic on both sides, including reserved addresses
        for (int i = 0; i < 30; i++) begin
            for (int s = 0; s < 2; s++) begin
                r = $urandom_range(0, 9);
                ra = (r == 0) ? 10'h3FE : (r == 1) ? 10'h3FF : (10'h100 + 10'(r));
                push_cmd(s, 1'($urandom_range(0, 1)), ra, 8'($urandom), 3'($urandom_range(0, 3)));
            end
        end
        wait_idle(2000);

        bad = 0;
        for (int i = 0; i < 1024; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
        chk("mem_vs_model", bad, 32'd0);
        chk("res_in_port_untouched", {24'd0, tb_mem[10'h3FE]}, {24'd0, init_mem[10'h3FE]});
        chk("bus_invariants", inv_err, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
